gate_trigger_fanout: RTL



---
 rtl/wirelog_trig_pkg.sv | 24 ++
 rtl/trig_index_counter.sv | 54 +++++
 rtl/gate_trigger_fanout.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wirelog_trig_pkg.sv
// -----------------------------------------------------------------------------
// wirelog_trig_pkg
//   Shared types and constants for the gate trigger fan-out stage.
//   - trig_state_e : fan-out sequencer states (IDLE waits for a change,
//                    SEND walks the output wires one trigger at a time)
//   - STATS_W      : width of the optional fire counter
//   - idx_w()      : width of a wire index for a given output count,
//                    never narrower than one bit
// -----------------------------------------------------------------------------
package wirelog_trig_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } trig_state_e;

  localparam int STATS_W = 16;

  // A single-output gate still needs a 1-bit index port, so clamp at 1.
  function automatic int idx_w(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/trig_index_counter.sv
// -----------------------------------------------------------------------------
// trig_index_counter
//   Holds the index of the output wire currently being triggered.
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous, active-high reset (index returns to 0)
//     clr   in   force index to 0 (start of a new fan-out)
//     adv   in   trigger accepted this cycle: step to next wire, wrapping
//                to 0 after the last wire
//     idx   out  current wire index
//     last  out  current index is the final wire (COUNT-1)
// -----------------------------------------------------------------------------
module trig_index_counter #(
  parameter int COUNT = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  assign last = (idx_q == W'(COUNT - 1));
  assign idx  = idx_q;

  // NOTE: every variable written in an always_comb gets a default on entry;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (adv) begin
      // Wrapping here leaves the index at 0 when the fan-out completes, so
      // trig_wire idles at 0 without any extra gating.
      idx_d = last ? '0 : idx_q + W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/gate_trigger_fanout.sv
// -----------------------------------------------------------------------------
// gate_trigger_fanout
//   Watches a gate's result bit and, when it changes, emits one trigger per
//   output wire over a valid/ready handshake. A gate fires at most once per
//   logic frame; a change seen after the gate already fired this frame waits
//   until the next frame_start (or is absorbed if the level returns first).
//
//   Parameters:
//     OUTPUT_COUNT  number of output wires driven by this gate (>= 1)
//     INIT_LEVEL    gate level assumed after reset
//     IDX_W         derived wire-index width; leave at its default
//
//   Ports:
//     clk          in   system clock
//     logic_reset  in   asynchronous, active-high reset; drops any fan-out
//     frame_start  in   one-cycle pulse marking a new logic frame
//     gate_in      in   gate result level
//     trig_ready   in   wire network accepts the presented trigger
//     trig_valid   out  trigger presented
//     trig_wire    out  index of the wire being triggered
//     trig_level   out  new gate level carried by the trigger (0 when idle)
//     busy         out  fan-out in progress
//     fired        out  gate has already fired in the current frame
//
//   Optional build macro GATE_TRIG_STATS_EN adds:
//     fire_count   out  16-bit wrapping count of fan-outs started
//     deferred     out  a change is waiting for the next frame
// -----------------------------------------------------------------------------
module gate_trigger_fanout
  import wirelog_trig_pkg::*;
#(
  parameter int OUTPUT_COUNT = 2,
  parameter bit INIT_LEVEL   = 1'b0,
  parameter int IDX_W        = idx_w(OUTPUT_COUNT)
) (
  input  logic             clk,
  input  logic             logic_reset,
  input  logic             frame_start,
  input  logic             gate_in,
  input  logic             trig_ready,
  output logic             trig_valid,
  output logic [IDX_W-1:0] trig_wire,
  output logic             trig_level,
  output logic             busy,
  output logic             fired
`ifdef GATE_TRIG_STATS_EN
  ,
  output logic [STATS_W-1:0] fire_count,
  output logic               deferred
`endif
);

  trig_state_e state_q, state_d;
  logic        last_level_q, last_level_d;
  logic        fired_q, fired_d;
  logic        level_q, level_d;

  logic        change;
  logic        start;
  logic        idx_last;
  logic        handshake;
  logic        sending;

  // Compare against the level last committed to the network, not the
  // previous cycle's input: a pulse that returns before firing is absorbed.
  assign change    = (gate_in != last_level_q);
  assign sending   = (state_q == ST_SEND);
  assign handshake = sending && trig_ready;

  // ---------------------------------------------------------------------------
  // Wire index
  // ---------------------------------------------------------------------------
  trig_index_counter #(
    .COUNT (OUTPUT_COUNT),
    .W     (IDX_W)
  ) u_idx (
    .clk  (clk),
    .rst  (logic_reset),
    .clr  (start),
    .adv  (handshake),
    .idx  (trig_wire),
    .last (idx_last)
  );

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_level_d = last_level_q;
    fired_d      = fired_q;
    level_d      = level_q;
    start        = 1'b0;

    // A new frame re-arms the gate in any state; a fire in this same cycle
    // overrides it below, so frame_start + change fires immediately and
    // leaves the gate marked for the new frame.
    if (frame_start) begin
      fired_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (change && (!fired_q || frame_start)) begin
          start        = 1'b1;
          level_d      = gate_in;
          last_level_d = gate_in;
          fired_d      = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        // Changes during SEND are not acted on here; they stay visible as
        // gate_in != last_level and are picked up once back in IDLE.
        if (handshake && idx_last) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      state_q      <= ST_IDLE;
      last_level_q <= INIT_LEVEL;
      fired_q      <= 1'b0;
      level_q      <= INIT_LEVEL;
    end else begin
      state_q      <= state_d;
      last_level_q <= last_level_d;
      fired_q      <= fired_d;
      level_q      <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign trig_valid = sending;
  assign busy       = sending;
  // Gated so an idle port shows all zeros regardless of INIT_LEVEL.
  assign trig_level = sending & level_q;
  assign fired      = fired_q;

`ifdef GATE_TRIG_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [STATS_W-1:0] fire_count_q, fire_count_d;

  always_comb begin
    fire_count_d = fire_count_q;
    if (start) begin
      fire_count_d = fire_count_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      fire_count_q <= '0;
    end else begin
      fire_count_q <= fire_count_d;
    end
  end

  assign fire_count = fire_count_q;
  assign deferred   = (state_q == ST_IDLE) && change && fired_q && !frame_start;
`endif

endmodule
